// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared types and helpers for the ROB retirement controller.
package rr_pkg;

  localparam int P_ADDR_WIDTH_DEF = 7;

  function automatic int rid_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    REC  = 2'd1,
    HOLD = 2'd2
  } commit_state_e;

  typedef struct packed {
    logic [P_ADDR_WIDTH_DEF-1:0] ppdst;
    logic                        exec;
  } lane_t;

endpackage

// File: rtl/commit_prefix_sel.sv
// rtl/commit_prefix_sel.sv - in-order prefix pop selection and popcount across retire lanes.
module commit_prefix_sel
  import rr_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic             i_en,
  input  logic [LANES-1:0] i_valid,
  input  logic [LANES-1:0] i_exec,
  output logic [LANES-1:0] o_pop,
  output logic [CW-1:0]    o_count
);

  logic w_carry;

  // A lane retires only if every older lane retires in the same cycle.
  always_comb begin
    o_pop   = '0;
    o_count = '0;
    w_carry = i_en;
    for (int i = 0; i < LANES; i++) begin
      o_pop[i] = w_carry & i_valid[i] & i_exec[i];
      w_carry  = o_pop[i];
      o_count  = o_count + CW'(o_pop[i]);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB in-order commit, free-list release stage and flush recovery sequencer.
module rob_commit_ctrl
  import rr_pkg::*;
#(
  parameter  int ROB_DEPTH    = 128,
  parameter  int P_ADDR_WIDTH = 7,
  parameter  int INSTR_COUNT  = 2,
  parameter  int FLUSH_HOLD   = 2,
  parameter  int CNT_W        = 32,
  localparam int RID_W        = rid_w(ROB_DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [INSTR_COUNT-1:0]                   i_rob_valid,
  input  logic [INSTR_COUNT-1:0]                   i_rob_exec,
  input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] i_rob_ppdst,
  output logic [INSTR_COUNT-1:0]                   o_rob_pop,
  input  logic                                     i_fl_ready,
  output logic [INSTR_COUNT-1:0]                   o_fl_push,
  output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] o_fl_data,
  input  logic                                     i_halt,
  input  logic                                     i_flush_req,
  input  logic [RID_W-1:0]                         i_flush_id,
  output logic                                     o_flush_ready,
  output logic                                     o_rec_en,
  output logic [RID_W-1:0]                         o_rec_id,
  output logic [CNT_W-1:0]                         o_retired_cnt,
  output logic [CNT_W-1:0]                         o_stall_cnt
);

  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam int PC_W   = $clog2(INSTR_COUNT + 1);

  commit_state_e                          r_state, w_state_nxt;
  logic [HOLD_W-1:0]                      r_hold_cnt, w_hold_nxt;
  logic                                   w_accept, w_ok;
  logic [INSTR_COUNT-1:0]                 w_pop;
  logic [PC_W-1:0]                        w_pop_cnt;
  logic [INSTR_COUNT-1:0]                 r_fl_push;
  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] r_fl_data;
  logic                                   r_rec_en;
  logic [RID_W-1:0]                       r_rec_id;
  logic [CNT_W-1:0]                       r_retired_cnt, r_stall_cnt;

  assign o_flush_ready = (r_state == RUN);
  assign w_accept      = i_flush_req & o_flush_ready;
  // A pending flush request blocks commit even in its acceptance cycle.
  assign w_ok          = o_flush_ready & ~i_halt & ~i_flush_req & i_fl_ready;

  commit_prefix_sel #(
    .LANES (INSTR_COUNT),
    .CW    (PC_W)
  ) u_prefix (
    .i_en    (w_ok),
    .i_valid (i_rob_valid),
    .i_exec  (i_rob_exec),
    .o_pop   (w_pop),
    .o_count (w_pop_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      RUN: begin
        if (w_accept) w_state_nxt = REC;
      end
      REC: begin
        w_state_nxt = HOLD;
        w_hold_nxt  = HOLD_W'(FLUSH_HOLD - 1);
      end
      HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = RUN;
        else                  w_hold_nxt  = r_hold_cnt - 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_hold_cnt    <= '0;
      r_rec_en      <= 1'b0;
      r_rec_id      <= '0;
      r_fl_push     <= '0;
      r_fl_data     <= '0;
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rec_en   <= w_accept;
      if (w_accept) r_rec_id <= i_flush_id;
      r_fl_push <= w_pop;
      for (int i = 0; i < INSTR_COUNT; i++) begin
        if (w_pop[i]) r_fl_data[i] <= i_rob_ppdst[i];
      end
      r_retired_cnt <= r_retired_cnt + CNT_W'(w_pop_cnt);
      if (i_rob_valid[0] & ~w_pop[0]) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_rob_pop     = w_pop;
  assign o_fl_push     = r_fl_push;
  assign o_fl_data     = r_fl_data;
  assign o_rec_en      = r_rec_en;
  assign o_rec_id      = r_rec_id;
  assign o_retired_cnt = r_retired_cnt;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - scoreboard bench for rob_commit_ctrl with directed commit/flush vectors.
module tb_rob_commit_ctrl;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      rob_valid, rob_exec, rob_pop, fl_push;
  logic [1:0][6:0] rob_ppdst, fl_data;
  logic            fl_ready, halt, flush_req, flush_ready, rec_en;
  logic [6:0]      flush_id, rec_id;
  logic [31:0]     retired_cnt, stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]      push;
    logic [1:0][6:0] data;
    int              due;
  } rel_t;
  typedef struct {
    logic [6:0] id;
    int         due;
  } rec_t;

  rel_t            rel_q[$];
  rec_t            rec_q[$];
  logic [1:0][6:0] mdata;

  rob_commit_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rob_valid   (rob_valid),
    .i_rob_exec    (rob_exec),
    .i_rob_ppdst   (rob_ppdst),
    .o_rob_pop     (rob_pop),
    .i_fl_ready    (fl_ready),
    .o_fl_push     (fl_push),
    .o_fl_data     (fl_data),
    .i_halt        (halt),
    .i_flush_req   (flush_req),
    .i_flush_id    (flush_id),
    .o_flush_ready (flush_ready),
    .o_rec_en      (rec_en),
    .o_rec_id      (rec_id),
    .o_retired_cnt (retired_cnt),
    .o_stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a release or recover strobe.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fl_push != 2'b00) begin
        if (rel_q.size() == 0) check("fl_push_unexpected", 32'(fl_push), 32'd0);
        else begin
          rel_t r;
          r = rel_q.pop_front();
          check("fl_push", 32'(fl_push), 32'(r.push));
          check("fl_data", 32'(fl_data), 32'(r.data));
          check("fl_latency", 32'(cyc), 32'(r.due));
        end
      end
      if (rec_en) begin
        if (rec_q.size() == 0) check("rec_en_unexpected", 32'(rec_en), 32'd0);
        else begin
          rec_t r;
          r = rec_q.pop_front();
          check("rec_id", 32'(rec_id), 32'(r.id));
          check("rec_latency", 32'(cyc), 32'(r.due));
        end
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] e, input logic fr,
                      input logic freq, input logic [6:0] fid, input logic h,
                      input logic [6:0] p1, input logic [6:0] p0,
                      input logic [1:0] exp_pop, input logic exp_fr,
                      input int exp_ret, input int exp_stall);
    @(negedge clk);
    rob_valid    = v;
    rob_exec     = e;
    fl_ready     = fr;
    flush_req    = freq;
    flush_id     = fid;
    halt         = h;
    rob_ppdst[1] = p1;
    rob_ppdst[0] = p0;
    #2;
    check("rob_pop", 32'(rob_pop), 32'(exp_pop));
    check("flush_ready", 32'(flush_ready), 32'(exp_fr));
    check("retired_cnt", retired_cnt, 32'(exp_ret));
    check("stall_cnt", stall_cnt, 32'(exp_stall));
    if (exp_pop != 2'b00) begin
      for (int i = 0; i < 2; i++) if (exp_pop[i]) mdata[i] = rob_ppdst[i];
      rel_q.push_back('{push: exp_pop, data: mdata, due: cyc + 1});
    end
    if (freq && exp_fr) rec_q.push_back('{id: fid, due: cyc + 1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rob_valid = '0; rob_exec = '0; rob_ppdst = '0; fl_ready = 1'b0;
    halt = 1'b0; flush_req = 1'b0; flush_id = '0; mdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rob_pop", 32'(rob_pop), 32'd0);
    check("rst_fl_push", 32'(fl_push), 32'd0);
    check("rst_fl_data", 32'(fl_data), 32'd0);
    check("rst_rec_en", 32'(rec_en), 32'd0);
    check("rst_rec_id", 32'(rec_id), 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_flush_ready", 32'(flush_ready), 32'd1);
    rst_n = 1'b1;

    //    valid  exec   fr  freq fid h  p1  p0   pop    fr ret st
    step(2'b11, 2'b11, 1, 0, 0,  0, 5,  9,  2'b11, 1, 0, 0);   // basic commit
    step(2'b11, 2'b10, 1, 0, 0,  0, 3,  12, 2'b00, 1, 2, 0);   // lane0 not executed
    step(2'b11, 2'b01, 1, 0, 0,  0, 3,  12, 2'b01, 1, 2, 1);   // only lane0 retires
    step(2'b11, 2'b11, 0, 0, 0,  0, 21, 20, 2'b00, 1, 3, 1);   // backpressure x3
    step(2'b11, 2'b11, 0, 0, 0,  0, 21, 20, 2'b00, 1, 3, 2);
    step(2'b11, 2'b11, 0, 0, 0,  0, 21, 20, 2'b00, 1, 3, 3);
    step(2'b11, 2'b11, 1, 0, 0,  0, 21, 20, 2'b11, 1, 3, 4);
    step(2'b11, 2'b11, 1, 0, 0,  1, 21, 20, 2'b00, 1, 5, 4);   // halt
    step(2'b11, 2'b11, 1, 1, 37, 0, 21, 20, 2'b00, 1, 5, 5);   // flush accepted
    step(2'b11, 2'b11, 1, 0, 0,  0, 21, 20, 2'b00, 0, 5, 6);   // REC
    step(2'b11, 2'b11, 1, 1, 50, 0, 21, 20, 2'b00, 0, 5, 7);   // HOLD 1, req refused
    step(2'b11, 2'b11, 1, 1, 50, 0, 21, 20, 2'b00, 0, 5, 8);   // HOLD 2
    step(2'b11, 2'b11, 1, 1, 50, 0, 21, 20, 2'b00, 1, 5, 9);   // RUN, accepted
    step(2'b11, 2'b11, 1, 0, 0,  0, 21, 20, 2'b00, 0, 5, 10);
    step(2'b11, 2'b11, 1, 0, 0,  0, 21, 20, 2'b00, 0, 5, 11);
    step(2'b11, 2'b11, 1, 0, 0,  0, 21, 20, 2'b00, 0, 5, 12);
    step(2'b11, 2'b11, 1, 0, 0,  0, 2,  1,  2'b11, 1, 5, 13);  // commit resumes
    step(2'b01, 2'b11, 1, 0, 0,  0, 30, 7,  2'b01, 1, 7, 13);  // valid gates lane1
    step(2'b00, 2'b00, 1, 0, 0,  0, 0,  0,  2'b00, 1, 8, 13);
    step(2'b00, 2'b00, 1, 1, 99, 0, 0,  0,  2'b00, 1, 8, 13);  // flush, then reset in REC

    @(negedge clk);
    flush_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rec_en", 32'(rec_en), 32'd0);
    check("midrst_rec_id", 32'(rec_id), 32'd0);
    check("midrst_fl_push", 32'(fl_push), 32'd0);
    check("midrst_retired", retired_cnt, 32'd0);
    check("midrst_stall", stall_cnt, 32'd0);
    check("midrst_flush_ready", 32'(flush_ready), 32'd1);
    mdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b11, 2'b11, 1, 0, 0,  0, 6,  4,  2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0,  0, 0,  0,  2'b00, 1, 2, 0);

    repeat (3) @(negedge clk);
    check("rel_q_drained", 32'(rel_q.size()), 32'd0);
    check("rec_q_drained", 32'(rec_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order retirement controller for the ROB.
- Each cycle it inspects the ROB head window (valid / exec / PPdst) and drives a thermometer pop to the ROB.
- Releases the retired instructions' previous physical destinations to the free list, with one registered stage and backpressure.
- Sequences misprediction recovery: accepts a flush request, pulses rec_en/rec_id to the ROB, then holds commit for a programmable number of cycles.

Parameters:
- ROB_DEPTH, 128, ROB entries; ID width RID_W = $clog2(ROB_DEPTH).
- P_ADDR_WIDTH, 7, physical register address width.
- INSTR_COUNT, 2, commit lanes per cycle.
- FLUSH_HOLD, 2, commit-blocked cycles after the rec_en pulse (>=1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rob_valid  in  INSTR_COUNT  ROB head-window occupancy (thermometer).
- rob_exec  in  INSTR_COUNT  entry executed flag per lane.
- rob_ppdst  in  INSTR_COUNT x P_ADDR_WIDTH  previous physical dst per lane.
- rob_pop  out  INSTR_COUNT  pop to ROB (thermometer, combinational).
- fl_ready  in  1  free list can accept INSTR_COUNT releases next cycle.
- fl_push  out  INSTR_COUNT  release valid per lane (registered).
- fl_data  out  INSTR_COUNT x P_ADDR_WIDTH  released register (registered).
- halt  in  1  debug stall; blocks commit while high.
- flush_req  in  1  recovery request.
- flush_id  in  RID_W  ROB id to rewind tail to.
- flush_ready  out  1  flush accepted when flush_req & flush_ready.
- rec_en  out  1  ROB recover strobe (registered, 1-cycle pulse).
- rec_id  out  RID_W  ROB recover id (registered).
- retired_cnt  out  CNT_W  total instructions retired.
- stall_cnt  out  CNT_W  cycles where rob_valid[0] is set but rob_pop[0] is clear.

Behaviour:
- Reset values:
  - FSM = RUN.
  - rob_pop, fl_push, fl_data, rec_en, rec_id, retired_cnt, stall_cnt = 0.
  - flush_ready = 1.
- FSM states: RUN, REC, HOLD.
  - RUN -> REC on flush_req & flush_ready. Same edge: rec_id <= flush_id, rec_en <= 1.
  - REC (exactly 1 cycle, rec_en high) -> HOLD. Hold counter loads FLUSH_HOLD-1.
  - HOLD decrements each cycle -> RUN when it reaches 0; rec_en = 0 throughout HOLD.
- flush_ready = (state == RUN), combinational. A flush_req outside RUN is not accepted; the requester holds req and id until accepted.
- Commit condition, combinational:
  - ok = (state == RUN) & !halt & !flush_req & fl_ready.
  - rob_pop[0] = ok & rob_valid[0] & rob_exec[0].
  - rob_pop[i] = rob_pop[i-1] & rob_valid[i] & rob_exec[i].
  - Pop is always a prefix; no lane retires past an unexecuted or invalid older lane.
- Flush has priority over commit: in the acceptance cycle, and in REC and HOLD, rob_pop = 0.
- Release stage, 1-cycle latency:
  - fl_push <= rob_pop.
  - fl_data[i] <= rob_ppdst[i] when rob_pop[i], else holds its value.
- fl_ready low forces rob_pop = 0. The free list guarantees it can absorb the registered releases issued under fl_ready=1, so fl_push is never dropped.
- retired_cnt += popcount(rob_pop) each cycle; wraps modulo 2^CNT_W.
- stall_cnt += 1 when rob_valid[0] & !rob_pop[0], in any state; wraps.
- Asynchronous reset mid-REC/HOLD: returns to RUN immediately; any pending release in the fl_push register is discarded.
- Inputs rob_valid, rob_exec and rob_ppdst are assumed to reflect the ROB state in the current cycle (combinational ROB read path).

Decomposition:
- Shared package (rr_pkg): RID_W derivation, the commit FSM enum {RUN, REC, HOLD}, and a lane struct {ppdst, exec}.
- One natural sub-module: commit_prefix_sel. Combinational prefix/thermometer pop generation plus popcount for INSTR_COUNT lanes, reusable by other in-order retire logic.
- FSM, release register and counters stay in rob_commit_ctrl.

Test Plan:
- Basic commit: valid=11, exec=11, ppdst={5,9}, fl_ready=1 -> rob_pop=11; next cycle fl_push=11, fl_data={5,9}; retired_cnt 0->2.
- Prefix blocking: valid=11, exec=10 (lane0 not executed) -> rob_pop=00, stall_cnt +1. Then exec=01 -> rob_pop=01, fl_push=01 next cycle, retired_cnt +1.
- Backpressure: valid=11, exec=11, fl_ready=0 for 3 cycles -> rob_pop=00 for all 3 cycles, stall_cnt +3. fl_ready=1 -> rob_pop=11.
- Flush sequencing: flush_req=1, flush_id=37 while commits are ready -> same cycle rob_pop=00, flush_ready=1. Next cycle rec_en=1, rec_id=37, flush_ready=0. Then 2 HOLD cycles with rob_pop=00. RUN resumes on the 4th cycle after acceptance.
- Flush during HOLD: second flush_req at HOLD cycle 1 -> not accepted, flush_ready=0; accepted on the first RUN cycle, giving a second rec_en pulse exactly 1 cycle later.
- Reset mid-flush: assert rst_n=0 during REC -> rec_en, fl_push and counters read 0 immediately; after release: state RUN, flush_ready=1.
